// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing one BCD decoder.
// Define SEG7_LZB_EN to enable leading-zero blanking; the default build drives every digit.
module seg7_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned GUARD_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [3:0]              bcd,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp,
   output logic                    pending,
   output logic                    commit
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = $clog2(NUM_DIGITS);

   typedef enum logic {StGuard, StDrive} state_t;

   state_t                     state_q;
   logic [CW-1:0]              cnt_q;
   logic [IW-1:0]              idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0] act_dig_q, pend_dig_q, show_dig;
   logic [NUM_DIGITS-1:0]      act_dp_q, pend_dp_q, show_dp;
   logic [NUM_DIGITS-1:0]      an_sel;
   logic                       tick, last_slot, do_commit, guard_end;

`ifdef SEG7_LZB_EN
   logic [NUM_DIGITS-1:0]      blank_q, show_blank;

   // Walk down from the top digit; the first nonzero digit or lit dp stops blanking.
   function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [NUM_DIGITS-1:0][3:0] d,
                                                      input logic [NUM_DIGITS-1:0]      p);
      logic keep;
      keep     = 1'b0;
      lzb_mask = '0;
      for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
         keep        = keep | (d[k] != 4'd0) | p[k];
         lzb_mask[k] = ~keep;
      end
   endfunction
`endif

   always_comb begin
      tick      = (cnt_q == CW'(REFRESH_DIV - 1));
      guard_end = (cnt_q == CW'(GUARD_CYCLES - 1));
      last_slot = (idx_q == IW'(NUM_DIGITS - 1));
      do_commit = tick && last_slot && pending;
      idx_d     = idx_q;
      if (tick) begin
         idx_d = last_slot ? '0 : idx_q + 1'b1;
      end
      // Slot 0 of the next frame must already show the data committed on this edge.
      show_dig  = do_commit ? pend_dig_q : act_dig_q;
      show_dp   = do_commit ? pend_dp_q  : act_dp_q;
      an_sel         = '1;
      an_sel[idx_q]  = 1'b0;
`ifdef SEG7_LZB_EN
      show_blank = do_commit ? lzb_mask(pend_dig_q, pend_dp_q) : blank_q;
`endif
   end

   // Double buffer: captures land in pending, move to active only at a frame boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pending    <= 1'b0;
         commit     <= 1'b0;
`ifdef SEG7_LZB_EN
         blank_q    <= '0;
`endif
      end else begin
         commit <= do_commit;
         if (do_commit) begin
            act_dig_q <= pend_dig_q;
            act_dp_q  <= pend_dp_q;
            pending   <= 1'b0;
`ifdef SEG7_LZB_EN
            blank_q   <= show_blank;
`endif
         end
         if (load) begin
            pend_dig_q <= digits_in;
            pend_dp_q  <= dp_in;
            pending    <= 1'b1;
         end
      end
   end

   // Slot timing and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StGuard;
         cnt_q   <= '0;
         idx_q   <= '0;
         an      <= '1;
         bcd     <= 4'd0;
         dp      <= 1'b1;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
         idx_q <= idx_d;
         unique case (state_q)
            StGuard: begin
               if (guard_end) begin
                  state_q <= StDrive;
`ifdef SEG7_LZB_EN
                  an      <= show_blank[idx_q] ? '1 : an_sel;
`else
                  an      <= an_sel;
`endif
               end
            end
            StDrive: begin
               if (tick) begin
                  state_q <= StGuard;
                  an      <= '1;
                  bcd     <= show_dig[idx_d];
`ifdef SEG7_LZB_EN
                  dp      <= ~show_dp[idx_d] | show_blank[idx_d];
`else
                  dp      <= ~show_dp[idx_d];
`endif
               end
            end
            default: state_q <= StGuard;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl at NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
// Expected slot contents are queued as stimulus is planned and popped at every slot start.
module tb_seg7_scan_ctrl;

   localparam int unsigned ND = 4;
   localparam int unsigned RD = 8;
   localparam int unsigned GC = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  bcd;
   logic [3:0]  an;
   logic        dp;
   logic        pending;
   logic        commit;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] bcd;
      logic       dp;
   } slot_t;

   slot_t sb[$];
   slot_t cur = '0;
   int    t = 0;
   int    n_vec = 0;
   int    n_bad = 0;
   int    n_commit = 0;
   bit    run = 1'b0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .GUARD_CYCLES (GC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .load      (load),
      .bcd       (bcd),
      .an        (an),
      .dp        (dp),
      .pending   (pending),
      .commit    (commit)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Queue one frame of expected slot outputs for committed digits d and dp requests p.
   task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input bit lzb);
      logic [3:0] blank;
      slot_t      e;
      blank = '0;
      for (int k = 1; k < ND; k++) begin
         blank[k] = lzb && ((d >> (4 * k)) == 16'd0) && ((p >> k) == 4'd0);
      end
`ifndef SEG7_LZB_EN
      blank = '0;
`endif
      for (int k = 0; k < ND; k++) begin
         e.an  = blank[k] ? 4'hF : ~(4'b0001 << k);
         e.bcd = d[4*k +: 4];
         e.dp  = blank[k] | ~p[k];
         sb.push_back(e);
      end
   endtask

   task automatic goto(input int n);
      int budget = 0;
      while (t != n && budget < 1000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("goto_cycle", t, n);
   endtask

   task automatic do_load(input int c, input logic [15:0] d, input logic [3:0] p);
      goto(c);
      digits_in = d;
      dp_in     = p;
      load      = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   always @(posedge clk) t <= reset ? 0 : t + 1;

   // Slot monitor: every cycle compared against the entry popped at the slot's first cycle.
   always @(negedge clk) begin
      if (run) begin
         if (t % RD == 0) begin
            if (sb.size() == 0) begin
               check("sb_underflow", sb.size(), 1);
               cur = '0;
            end else begin
               cur = sb.pop_front();
            end
         end
         check("an", an, (t % RD < GC) ? 4'hF : cur.an);
         check("bcd", bcd, cur.bcd);
         check("dp", dp, cur.dp);
         if (commit) n_commit++;
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation time limit reached (t=%0d)", t);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      push_frame(16'h0000, 4'b0000, 1'b0);
      push_frame(16'h1234, 4'b0000, 1'b1);
      run = 1'b1;

      goto(0);
      check("rst_pending", pending, 0);
      check("rst_commit", commit, 0);
      check("rst_an", an, 4'hF);
      goto(2);
      check("slot0_an", an, 4'hE);
      goto(10);
      check("slot1_an", an, 4'hD);

      do_load(12, 16'h1234, 4'b0000);
      check("pend_set", pending, 1);
      goto(31);
      check("pend_hold", pending, 1);
      check("no_early_commit", commit, 0);
      goto(32);
      check("commit1", commit, 1);
      check("pend_clr1", pending, 0);
      goto(33);
      check("commit1_end", commit, 0);

      push_frame(16'h2222, 4'b0000, 1'b1);
      do_load(40, 16'h1111, 4'b0000);
      do_load(50, 16'h2222, 4'b0000);
      goto(63);
      check("pend_last_wins", pending, 1);
      goto(64);
      check("commit2", commit, 1);
      check("pend_clr2", pending, 0);
      goto(66);
      check("commit_count2", n_commit, 2);

      push_frame(16'h9999, 4'b0000, 1'b1);
      push_frame(16'h5678, 4'b0100, 1'b1);
      do_load(70, 16'h9999, 4'b0000);
      do_load(95, 16'h5678, 4'b0100);
      check("boundary_commit", commit, 1);
      check("boundary_pend", pending, 1);
      goto(127);
      check("pend_5678", pending, 1);
      goto(128);
      check("commit4", commit, 1);
      goto(129);
      check("pend_clr4", pending, 0);
      check("commit_count4", n_commit, 4);

      push_frame(16'h5678, 4'b0100, 1'b1);
      push_frame(16'hABCD, 4'b0000, 1'b1);
      do_load(165, 16'hABCD, 4'b0000);
      goto(192);
      check("commit_hex", commit, 1);
      do_load(200, 16'h0001, 4'b0001);
      check("pend_pre_reset", pending, 1);
      goto(210);
      check("an_pre_reset", an, 4'b1011);

      sb.delete();
      push_frame(16'h0000, 4'b0000, 1'b0);
      push_frame(16'h0040, 4'b0000, 1'b1);
      push_frame(16'h0000, 4'b0000, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_an", an, 4'hF);
      check("mid_rst_pending", pending, 0);
      check("mid_rst_commit", commit, 0);
      check("mid_rst_bcd", bcd, 0);

      do_load(5, 16'h0040, 4'b0000);
      goto(32);
      check("commit_0040", commit, 1);
      do_load(40, 16'h0000, 4'b0000);
      goto(64);
      check("commit_0000", commit, 1);
      goto(95);
      check("final_pending", pending, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexes a single bcd27seg decoder across NUM_DIGITS common-anode displays in the stopwatch.
- Holds a double-buffered copy of the digit values. New values are committed only at frame boundaries, so the display never shows a mix of old and new digits.
- Drives `bcd` into the shared decoder, plus active-low anode selects and a decimal point.
- Inserts a guard interval at each digit switch to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ 4).
- GUARD_CYCLES, 500, cycles at the start of each slot with all anodes off (1 ≤ GUARD_CYCLES < REFRESH_DIV).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- digits_in  input  4*NUM_DIGITS  BCD digits; digit k is bits [4k+3:4k]; digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- load  input  1  capture strobe for digits_in and dp_in.
- bcd  output  4  digit value for the current slot, to the decoder input.
- an  output  NUM_DIGITS  anode enables, active-low.
- dp  output  1  decimal point, active-low.
- pending  output  1  high while a captured update awaits commit.
- commit  output  1  one-cycle pulse when pending data moves to the active buffer.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - cnt=0, idx=0, active and pending buffers cleared.
  - an=all 1, bcd=0, dp=1, pending=0, commit=0.
  - A reset mid-frame or mid-update discards the pending update and restarts at slot 0 in guard.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
  - On tick, idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Per-slot FSM:
  - GUARD while cnt < GUARD_CYCLES; DRIVE otherwise.
  - All outputs are registered.
  - On the edge where cnt wraps to 0: an becomes all 1, and bcd/dp load the active digit idx (new value).
  - On the edge where cnt becomes GUARD_CYCLES: an[idx] becomes 0; all other anode bits stay 1.
  - Exactly one anode is low in DRIVE; none are low in GUARD.
- Capture:
  - load=1 copies digits_in and dp_in into the pending buffer and sets pending=1.
  - Further loads before a commit overwrite the pending buffer (last value wins).
- Commit (frame boundary = tick while idx == NUM_DIGITS-1):
  - If pending=1: copy pending to active, pulse commit for one cycle, clear pending.
  - The new values are first displayed in slot 0 of the next frame.
- Simultaneous load and frame boundary: the commit uses the pending contents from before this edge. The new load lands in the pending buffer and pending stays 1. If pending was 0, nothing commits and pending becomes 1.
- No load during operation: the active buffer is redisplayed indefinitely.
- bcd values 10..15 are passed through unchanged; the decoder renders them as hex.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - At commit, compute the blank mask. Digit k is blanked if it and every higher digit are 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps an all 1 for its entire slot (dp also 1) while slot timing continues.
  - A lit decimal point on a digit stops blanking at that digit.
- Undefined: no blanking logic; every digit is driven in every slot.

Test Plan:
- Params 4/8/2. Release reset, no load -> an=1111 for cycles 0-1; an=1110, bcd=0 for cycles 2-7; then idx=1 with an=1101 from cycle 10. No slot ever has two anodes low.
- load with digits_in=0x1234 mid-frame (idx=1) -> pending=1 until the frame boundary. Then commit pulses once and pending=0. Next slot 0 shows bcd=4 and slot 3 shows bcd=1. Slots 1-3 of the current frame still show the old value 0.
- load 0x1111 then 0x2222 in the same frame -> one commit pulse; the next frame displays 2222.
- load 0x5678 on the exact frame-boundary cycle while 0x9999 is pending -> 9999 commits now, pending stays 1, and 5678 commits at the following boundary.
- Assert reset mid-DRIVE of slot 2 with pending=1 -> next cycle an=1111, idx=0, pending=0, commit=0; the display shows 0000 thereafter.
- SEG7_LZB_EN defined, digits 0x0040, dp_in=0 -> slots 3 and 2 have an=1111 throughout; slot 1 shows bcd=4; slot 0 shows bcd=0 with an=1110. With digits 0x0000, only slot 0 lights.
